// File: rtl/instruction_fetch_stage_pkg.sv
// rtl/instruction_fetch_stage_pkg.sv - shared constants and types for the IF stage
package instruction_fetch_stage_pkg;

  localparam logic [31:0] IF_NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2
  } if_state_t;

  // What the IF/ID register and pc do on the coming edge.
  typedef enum logic [1:0] {
    U_HOLD     = 2'd0,
    U_HAZARD   = 2'd1,
    U_REDIRECT = 2'd2,
    U_ADVANCE  = 2'd3
  } if_update_t;

  function automatic logic [31:0] byte_reverse(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - I-cache fetch port between IF stage and I-cache
interface instruction_fetch_stage_if;

  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;

  modport master (
    output ICACHE_ren,
    output ICACHE_addr,
    input  ICACHE_rdata,
    input  ICACHE_stall
  );

  modport slave (
    input  ICACHE_ren,
    input  ICACHE_addr,
    output ICACHE_rdata,
    output ICACHE_stall
  );

endinterface

// File: rtl/instruction_fetch_stage_sat_counter.sv
// rtl/instruction_fetch_stage_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: owns pc, fetches from I-cache, drives IF/ID register
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter bit          BYTE_SWAP = 1'b1,
  parameter logic [31:0] NOP_INSN  = IF_NOP_INSN,
  parameter int          CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       memory_stall,
  instruction_fetch_stage_if.master  icache,
  input  logic [31:0]                branch_address,
  input  logic                       PC_src,
  input  logic                       IF_flush,
  input  logic                       PC_write,
  input  logic [31:0]                IF_DWrite,
  output logic [31:0]                instruction_1,
  output logic [31:0]                PC_1,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  if_state_t   state_q, state_d;
  if_update_t  upd;
  logic [31:0] pc_q;
  logic [31:0] fetch_word;
  logic [31:0] redirect_pc;
  logic        fetch_ren;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fetch_ren = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        fetch_ren = 1'b1;
        if (icache.ICACHE_stall) state_d = S_MISS;
      end
      S_MISS: begin
        fetch_ren = 1'b1;
        if (!icache.ICACHE_stall) state_d = S_RUN;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Decode's redirect/flush is only honoured when the fetch actually completes
  // and no hazard is pending; otherwise decode re-presents it later.
  always_comb begin
    upd = U_HOLD;
    if (memory_stall || (state_q != S_RUN)) begin
      upd = U_HOLD;
    end else if (PC_write) begin
      upd = U_HAZARD;
    end else if (IF_flush || PC_src) begin
      upd = U_REDIRECT;
    end else begin
      upd = U_ADVANCE;
    end
  end

  always_comb begin
    fetch_word = icache.ICACHE_rdata;
    if (BYTE_SWAP) fetch_word = byte_reverse(icache.ICACHE_rdata);
  end

  assign redirect_pc = branch_address & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instruction_1 <= NOP_INSN;
      PC_1          <= RESET_PC;
    end else begin
      case (upd)
        U_HAZARD: begin
          instruction_1 <= IF_DWrite;
        end
        U_REDIRECT: begin
          pc_q          <= redirect_pc;
          instruction_1 <= NOP_INSN;
          PC_1          <= pc_q;
        end
        U_ADVANCE: begin
          pc_q          <= pc_q + 32'd4;
          instruction_1 <= fetch_word;
          PC_1          <= pc_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign icache.ICACHE_ren  = fetch_ren;
  assign icache.ICACHE_addr = pc_q[31:2];

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (memory_stall),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (upd == U_REDIRECT),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  localparam int          CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              memory_stall;
  logic [31:0]       branch_address;
  logic              PC_src, IF_flush, PC_write;
  logic [31:0]       IF_DWrite;
  logic [31:0]       instruction_1, PC_1;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  instruction_fetch_stage_if icif ();

  instruction_fetch_stage #(
    .RESET_PC  (32'h0),
    .BYTE_SWAP (1'b1),
    .NOP_INSN  (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .memory_stall   (memory_stall),
    .icache         (icif.master),
    .branch_address (branch_address),
    .PC_src         (PC_src),
    .IF_flush       (IF_flush),
    .PC_write       (PC_write),
    .IF_DWrite      (IF_DWrite),
    .instruction_1  (instruction_1),
    .PC_1           (PC_1),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  // Byte-addressed instruction memory; word 0 holds bytes 13 05 10 00.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24];
      end
    endcase
  endfunction

  // The cache delivers the word most-significant-byte-first (lowest address on top).
  function automatic logic [31:0] cache_word(input logic [29:0] wa);
    logic [31:0] a;
    a = {wa, 2'b00};
    return {mem_byte(a), mem_byte(a + 1), mem_byte(a + 2), mem_byte(a + 3)};
  endfunction

  assign icif.ICACHE_rdata = icif.ICACHE_stall ? 32'hDEAD_BEEF : cache_word(icif.ICACHE_addr);

  typedef struct {
    logic        ren;
    logic [29:0] addr;
    logic [31:0] ins;
    logic [31:0] pc1;
    int          sc;
    int          fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural pc, IF/ID contents, counters, boot/miss flags.
  logic [31:0] m_pc, m_ins, m_pc1;
  int          m_sc, m_fc;
  bit          m_boot, m_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rn, input bit is, input bit ds, input bit src,
                            input bit fl, input bit pw, input logic [31:0] dw,
                            input logic [31:0] ba);
    bit frozen;
    if (!rn) begin
      m_pc = 32'h0; m_ins = NOP; m_pc1 = 32'h0;
      m_sc = 0; m_fc = 0; m_boot = 1; m_miss = 0;
      return;
    end
    frozen = m_boot || m_miss || is || ds;
    if (is || ds) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    if (!frozen) begin
      if (pw) begin
        m_ins = dw;
      end else if (src || fl) begin
        m_pc1 = m_pc;
        m_pc  = {ba[31:2], 2'b00};
        m_ins = NOP;
        m_fc  = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      end else begin
        m_pc1 = m_pc;
        m_ins = {mem_byte(m_pc + 3), mem_byte(m_pc + 2), mem_byte(m_pc + 1), mem_byte(m_pc)};
        m_pc  = m_pc + 32'd4;
      end
    end
    if (m_boot) begin
      m_boot = 0;
      m_miss = 0;
    end else begin
      m_miss = is;
    end
  endtask

  task automatic do_cycle(input bit rn, input bit is, input bit ds, input bit src,
                          input bit fl, input bit pw, input logic [31:0] dw,
                          input logic [31:0] ba);
    exp_t e;
    rst_n             = rn;
    icif.ICACHE_stall = is;
    memory_stall      = is | ds;
    PC_src            = src;
    IF_flush          = fl;
    PC_write          = pw;
    IF_DWrite         = dw;
    branch_address    = ba;
    model_step(rn, is, ds, src, fl, pw, dw, ba);
    @(posedge clk);
    e.ren  = !m_boot;
    e.addr = m_pc[31:2];
    e.ins  = m_ins;
    e.pc1  = m_pc1;
    e.sc   = m_sc;
    e.fc   = m_fc;
    sb.push_back(e);
    #1;
  endtask

  task automatic idle();
    do_cycle(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("sb_ren", {31'b0, icif.ICACHE_ren}, {31'b0, mon_e.ren});
      check("sb_addr", {2'b0, icif.ICACHE_addr}, {2'b0, mon_e.addr});
      check("sb_instruction_1", instruction_1, mon_e.ins);
      check("sb_PC_1", PC_1, mon_e.pc1);
      check("sb_stall_cnt", 32'(stall_cnt), 32'(mon_e.sc));
      check("sb_flush_cnt", 32'(flush_cnt), 32'(mon_e.fc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; icif.ICACHE_stall = 0; memory_stall = 0;
    PC_src = 0; IF_flush = 0; PC_write = 0; IF_DWrite = 0; branch_address = 0;
    m_pc = 0; m_ins = NOP; m_pc1 = 0; m_sc = 0; m_fc = 0; m_boot = 1; m_miss = 0;
    repeat (2) @(posedge clk);
    #1;

    do_cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    do_cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("reset_ren", {31'b0, icif.ICACHE_ren}, 32'd0);
    check("reset_instruction_1", instruction_1, NOP);

    idle();
    check("boot_done_ren", {31'b0, icif.ICACHE_ren}, 32'd1);
    check("boot_done_addr", {2'b0, icif.ICACHE_addr}, 32'd0);
    idle();
    check("first_fetch_ins", instruction_1, 32'h0010_0513);
    check("first_fetch_pc1", PC_1, 32'h0);
    check("first_fetch_addr", {2'b0, icif.ICACHE_addr}, 32'd1);
    idle();

    repeat (5) do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("miss_addr_held", {2'b0, icif.ICACHE_addr}, 32'd2);
    check("miss_pc1_frozen", PC_1, 32'h4);
    check("miss_stall_cnt", 32'(stall_cnt), 32'd5);
    idle();
    idle();
    check("after_miss_pc1", PC_1, 32'h8);

    idle();
    do_cycle(1, 0, 0, 1, 1, 0, 32'h0, 32'h40);
    check("flush_ins", instruction_1, NOP);
    check("flush_pc1", PC_1, 32'h10);
    check("flush_addr", {2'b0, icif.ICACHE_addr}, 32'h10);
    check("flush_cnt_1", 32'(flush_cnt), 32'd1);

    do_cycle(1, 0, 0, 1, 0, 0, 32'h0, 32'h23);
    do_cycle(1, 0, 0, 1, 0, 1, 32'h0020_8663, 32'h80);
    check("hazard_addr", {2'b0, icif.ICACHE_addr}, 32'h8);
    check("hazard_ins", instruction_1, 32'h0020_8663);
    check("hazard_flush_cnt", 32'(flush_cnt), 32'd2);

    do_cycle(1, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFF);
    check("top_addr", {2'b0, icif.ICACHE_addr}, 32'h3FFF_FFFF);
    idle();
    check("wrap_addr", {2'b0, icif.ICACHE_addr}, 32'h0);
    check("wrap_pc1", PC_1, 32'hFFFF_FFFC);

    repeat (20) do_cycle(1, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("stall_cnt_sat", 32'(stall_cnt), CMAX);
    idle();
    repeat (14) do_cycle(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    check("flush_cnt_sat", 32'(flush_cnt), CMAX);

    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    do_cycle(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    do_cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("miss_reset_ren", {31'b0, icif.ICACHE_ren}, 32'd0);
    check("miss_reset_ins", instruction_1, NOP);
    check("miss_reset_stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      bit rn, is, ds, src, fl, pw;
      rn  = ($urandom_range(0, 199) != 0);
      is  = ($urandom_range(0, 7) == 0);
      ds  = ($urandom_range(0, 9) == 0);
      src = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      pw  = ($urandom_range(0, 7) == 0);
      do_cycle(rn, is, ds, src, fl, pw, $urandom, $urandom);
    end

    idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
